// File: rtl/l1_trigger_event_capture.sv
// l1_trigger_event_capture
// Merges per-beam trigger activity inside a fixed holdoff window into one
// timestamped event record, queues records in a first-word-fall-through FIFO
// and streams them out on a 128-bit AXI4-Stream port.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | armed when enable_i is high; first active trigger opens a window
// GATHER | OR trigger bits into the mask until the window counter expires
// WRITE  | push the finished record (or count it as dropped), triggers ignored

module l1_trigger_event_capture #(
    parameter int NBEAMS     = 2,
    parameter int HOLDOFF    = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              aclk,
    input  logic              reset_i,
    input  logic [NBEAMS-1:0] trig_i,
    input  logic              enable_i,
    output logic [127:0]      evt_tdata,
    output logic              evt_tvalid,
    input  logic              evt_tready,
    output logic [15:0]       drop_count_o
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_GATHER = 2'd1,
        S_WRITE  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [7:0]        win_cnt;
    logic [7:0]        win_cnt_nxt;
    logic [47:0]       ts;
    logic [47:0]       ev_ts;
    logic [47:0]       ev_ts_nxt;
    logic [NBEAMS-1:0] ev_mask;
    logic [NBEAMS-1:0] ev_mask_nxt;
    logic              push_req;

    logic [15:0]       seq;
    logic [15:0]       drop_count;
    logic [127:0]      rec;

    logic [127:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       occ;
    logic              fifo_full;
    logic              pop;
    logic              push_ok;

    // Free-running 48-bit timestamp, zero in the first cycle after reset.
    always_ff @(posedge aclk or posedge reset_i) begin
        if (reset_i) begin
            ts <= '0;
        end else begin
            ts <= ts + 48'd1;
        end
    end

    // FSM and event-capture registers.
    always_ff @(posedge aclk or posedge reset_i) begin
        if (reset_i) begin
            state   <= S_IDLE;
            win_cnt <= '0;
            ev_ts   <= '0;
            ev_mask <= '0;
        end else begin
            state   <= state_nxt;
            win_cnt <= win_cnt_nxt;
            ev_ts   <= ev_ts_nxt;
            ev_mask <= ev_mask_nxt;
        end
    end

    // Next-state logic. The window counter is loaded with HOLDOFF-1 in the
    // opening cycle, so GATHER lasts HOLDOFF-1 cycles and the window spans
    // exactly HOLDOFF cycles including the opening one.
    always_comb begin
        state_nxt   = state;
        win_cnt_nxt = win_cnt;
        ev_ts_nxt   = ev_ts;
        ev_mask_nxt = ev_mask;
        push_req    = 1'b0;
        case (state)
            S_IDLE: begin
                if (enable_i && (|trig_i)) begin
                    ev_ts_nxt   = ts;
                    ev_mask_nxt = trig_i;
                    win_cnt_nxt = 8'(HOLDOFF - 1);
                    state_nxt   = S_GATHER;
                end
            end
            S_GATHER: begin
                ev_mask_nxt = ev_mask | trig_i;
                win_cnt_nxt = win_cnt - 8'd1;
                if (win_cnt == 8'd1) begin
                    state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                push_req  = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Assemble the outgoing record from the captured event fields.
    always_comb begin
        rec              = '0;
        rec[127:112]     = seq;
        rec[111:64]      = ev_ts;
        rec[63:48]       = drop_count;
        rec[NBEAMS-1:0]  = ev_mask;
    end

    // A full FIFO still accepts when the head leaves in the same cycle: the
    // write slot then equals the slot being vacated.
    assign fifo_full = (occ == (AW + 1)'(FIFO_DEPTH));
    assign pop       = evt_tvalid && evt_tready;
    assign push_ok   = push_req && (!fifo_full || pop);

    // Record storage; contents are only observed while occupancy is nonzero.
    always_ff @(posedge aclk) begin
        if (push_ok) begin
            mem[wr_ptr] <= rec;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge aclk or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    // Sequence number advances per accepted record; drops saturate.
    always_ff @(posedge aclk or posedge reset_i) begin
        if (reset_i) begin
            seq        <= '0;
            drop_count <= '0;
        end else begin
            if (push_ok) begin
                seq <= seq + 16'd1;
            end
            if (push_req && !push_ok && (drop_count != 16'hFFFF)) begin
                drop_count <= drop_count + 16'd1;
            end
        end
    end

    assign evt_tvalid   = (occ != '0);
    assign evt_tdata    = evt_tvalid ? mem[rd_ptr] : '0;
    assign drop_count_o = drop_count;

endmodule

// File: tb/tb_l1_trigger_event_capture.sv
// Testbench for l1_trigger_event_capture: directed scenarios plus random
// traffic, checked by a window-level reference model and a record scoreboard.

module tb_l1_trigger_event_capture;

    localparam int NB = 2;
    localparam int H  = 16;
    localparam int D  = 16;

    typedef logic [127:0] rec_t;

    logic          aclk = 1'b0;
    logic          rst  = 1'b1;
    logic [NB-1:0] trig = '0;
    logic          en   = 1'b0;
    logic          rdy  = 1'b0;
    logic [127:0]  evt_tdata;
    logic          evt_tvalid;
    logic [15:0]   drop_count_o;

    int errors = 0;
    int checks = 0;

    rec_t          exp_q[$];
    longint        m_ts    = 0;
    int            m_occ   = 0;
    int            m_seq   = 0;
    int            m_drop  = 0;
    bit            m_act   = 0;
    longint        m_start = 0;
    logic [NB-1:0] m_mask  = '0;

    l1_trigger_event_capture #(
        .NBEAMS     (NB),
        .HOLDOFF    (H),
        .FIFO_DEPTH (D)
    ) dut (
        .aclk         (aclk),
        .reset_i      (rst),
        .trig_i       (trig),
        .enable_i     (en),
        .evt_tdata    (evt_tdata),
        .evt_tvalid   (evt_tvalid),
        .evt_tready   (rdy),
        .drop_count_o (drop_count_o)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic rec_t make_rec(input int seq, input longint ts, input int drop,
                                      input logic [NB-1:0] mask);
        rec_t r;
        r             = '0;
        r[127:112]    = 16'(seq);
        r[111:64]     = 48'(ts);
        r[63:48]      = 16'(drop);
        r[NB-1:0]     = mask;
        return r;
    endfunction

    // Monitor and reference model, evaluated mid-cycle for the upcoming edge.
    always @(negedge aclk) begin
        bit pop;
        bit acc;
        if (rst) begin
            chk("reset_tvalid", evt_tvalid, 0);
            chk("reset_tdata", evt_tdata, 0);
            exp_q.delete();
            m_ts = 0; m_occ = 0; m_seq = 0; m_drop = 0; m_act = 0; m_mask = '0;
        end else begin
            chk("tvalid", evt_tvalid, m_occ != 0);
            chk("drop_count", drop_count_o, m_drop);
            if (evt_tvalid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_record: got %h expected none", evt_tdata);
                end else begin
                    chk("record", evt_tdata, exp_q[0]);
                    if (rdy) void'(exp_q.pop_front());
                end
            end
            pop = (m_occ > 0) && rdy;
            acc = 0;
            if (m_act) begin
                if (m_ts <= m_start + H - 1) begin
                    m_mask |= trig;
                end else begin
                    acc = (m_occ < D) || pop;
                    if (acc) begin
                        exp_q.push_back(make_rec(m_seq, m_start, m_drop, m_mask));
                        m_seq = (m_seq + 1) % 65536;
                    end else if (m_drop < 65535) begin
                        m_drop++;
                    end
                    m_act = 0;
                end
            end else if (en && (|trig)) begin
                m_act   = 1;
                m_start = m_ts;
                m_mask  = trig;
            end
            m_occ = m_occ + int'(acc) - int'(pop);
            m_ts++;
        end
    end

    task automatic cyc(input logic [NB-1:0] t, input logic e, input logic r);
        trig = t;
        en   = e;
        rdy  = r;
        @(posedge aclk);
        #1;
    endtask

    task automatic idle_to(input longint n, input logic e, input logic r);
        int guard = 0;
        while (m_ts < n && guard < 20000) begin
            cyc('0, e, r);
            guard++;
        end
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        trig = '0;
        repeat (2) @(posedge aclk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        longint t0;
        repeat (3) @(posedge aclk);
        #1;
        rst = 1'b0;
        chk("post_reset_drop", drop_count_o, 0);
        chk("post_reset_tvalid", evt_tvalid, 0);

        // Single trigger at ts=100.
        idle_to(100, 1, 1);
        cyc(2'b01, 1, 1);
        idle_to(116, 1, 1);
        chk("single_early_valid", evt_tvalid, 0);
        cyc('0, 1, 1);
        chk("single_latency", evt_tvalid, 1);
        chk("single_record", evt_tdata, {16'd0, 48'd100, 16'd0, 48'd1});

        // Merge window, WRITE-cycle pulse ignored, next pulse re-arms.
        idle_to(200, 1, 1);
        cyc(2'b01, 1, 1);
        idle_to(215, 1, 1);
        cyc(2'b10, 1, 1);
        cyc(2'b10, 1, 1);
        chk("merge_record", evt_tdata, {16'd1, 48'd200, 16'd0, 48'd3});
        cyc(2'b10, 1, 1);
        idle_to(234, 1, 1);
        chk("rearm_record", evt_tdata, {16'd2, 48'd217, 16'd0, 48'd2});
        idle_to(260, 1, 1);

        // Backpressure and overflow from a fresh reset.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            cyc(2'b01, 1, 0);
            repeat (19) cyc('0, 1, 0);
        end
        chk("overflow_drops", drop_count_o, 4);
        chk("overflow_head", evt_tdata, {16'd0, 48'd0, 16'd0, 48'd1});
        repeat (20) cyc('0, 1, 1);
        t0 = m_ts;
        cyc(2'b01, 1, 0);
        repeat (16) cyc('0, 1, 0);
        chk("after_drop_record", evt_tdata, {16'd16, 48'(t0), 16'd4, 48'd1});
        repeat (5) cyc('0, 1, 1);

        // Full FIFO with a pop coinciding with WRITE.
        for (int i = 0; i < D; i++) begin
            cyc(2'b10, 1, 0);
            repeat (17) cyc('0, 1, 0);
        end
        cyc(2'b11, 1, 0);
        repeat (H - 1) cyc('0, 1, 0);
        cyc('0, 1, 1);
        repeat (3) cyc('0, 1, 0);
        chk("full_pop_drops", drop_count_o, 4);
        chk("full_pop_valid", evt_tvalid, 1);
        repeat (25) cyc('0, 1, 1);

        // Enable low: triggers are ignored.
        repeat (60) cyc(NB'($urandom_range(0, 3)), 0, 1);
        chk("disabled_no_record", evt_tvalid, 0);

        // Enable dropped mid-window: event still completes.
        cyc(2'b01, 1, 1);
        repeat (5) cyc(2'b10, 0, 1);
        repeat (20) cyc('0, 0, 1);

        // Reset mid-GATHER with three records queued.
        for (int i = 0; i < 3; i++) begin
            cyc(2'b01, 1, 0);
            repeat (19) cyc('0, 1, 0);
        end
        cyc(2'b10, 1, 0);
        repeat (5) cyc('0, 1, 0);
        rst = 1'b1;
        #1;
        chk("reset_drop_valid", evt_tvalid, 0);
        chk("reset_drop_data", evt_tdata, 0);
        repeat (2) @(posedge aclk);
        #1;
        rst = 1'b0;
        idle_to(3, 1, 1);
        cyc(2'b01, 1, 1);
        idle_to(20, 1, 1);
        chk("after_reset_record", evt_tdata, {16'd0, 48'd3, 16'd0, 48'd1});

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            logic [NB-1:0] t;
            t = ($urandom_range(0, 5) == 0) ? NB'($urandom_range(0, 3)) : '0;
            cyc(t, ($urandom_range(0, 9) != 0), (i % 1000 < 400) ? 1'b0 : ($urandom_range(0, 9) < 7));
        end

        repeat (60) cyc('0, 0, 1);
        chk("final_queue_empty", exp_q.size(), 0);
        chk("final_tvalid", evt_tvalid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
